// File: rtl/uart_pkg.sv
// Shared UART types: TX controller state encoding, line idle level and the
// per-frame format record reused by the receive side.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic UART_IDLE_LVL = 1'b1;

  typedef struct packed {
    logic par_en;
    logic par_odd;
    logic stop2;
  } uart_cfg_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..P-1 with P = max(div,1) and flags the last clock
// of every bit period. restart realigns the period to the current clock edge.
module uart_baud_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             restart,
  input  logic [DIV_W-1:0] div,
  output logic             bit_tick,
  output logic             tick_next
);

  logic [DIV_W-1:0] cnt_reg;
  logic [DIV_W-1:0] cnt_next;
  logic [DIV_W-1:0] last_cnt;

  // ">=" keeps the counter bounded even if div shrinks while idle.
  always_comb begin
    last_cnt = (div > DIV_W'(1)) ? (div - DIV_W'(1)) : '0;
    if (restart || (cnt_reg >= last_cnt)) begin
      cnt_next = '0;
    end else begin
      cnt_next = cnt_reg + DIV_W'(1);
    end
    tick_next = (cnt_next == last_cnt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg  <= '0;
      bit_tick <= 1'b0;
    end else begin
      cnt_reg  <= cnt_next;
      bit_tick <= tick_next;
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: pops the TX FIFO and serializes each word as
// start, LSB-first data, optional parity and one or two stop bits.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tx_en,
  input  logic [DIV_W-1:0] baud_div,
  input  logic             par_en,
  input  logic             par_odd,
  input  logic             stop2,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_rd_data,
  output logic             fifo_rd_en,
  output logic             tx,
  output logic             busy,
  output logic             frame_done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  tx_state_t        state;
  logic [WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0] bit_cnt;
  logic [DIV_W-1:0] div_reg;
  logic [DIV_W-1:0] gen_div;
  uart_cfg_t        cfg_reg;
  logic             par_bit;
  logic             stop_sec;
  logic             run_reg;
  logic             bit_tick;
  logic             tick_next;
  logic             final_stop;
  logic             last_stop;
  logic             final_next;
  logic             pop;

  // run_reg holds off the first edge after reset release so no pop lands there.
  assign final_stop = (state == STOP) && (stop_sec || !cfg_reg.stop2);
  assign last_stop  = final_stop && bit_tick;
  assign pop        = run_reg && ((state == IDLE) || last_stop) && tx_en && !fifo_empty;
  assign fifo_rd_en = pop && rst_n;

  // On the pop edge the timer must already see the divisor being latched.
  assign gen_div = pop ? baud_div : div_reg;

  uart_baud_gen #(
    .DIV_W(DIV_W)
  ) u_baud (
    .clk      (clk),
    .rst_n    (rst_n),
    .restart  (pop),
    .div      (gen_div),
    .bit_tick (bit_tick),
    .tick_next(tick_next)
  );

  // Predicts whether the next clock sits inside the final stop bit, so the
  // registered frame_done can line up with that bit's last clock.
  always_comb begin
    final_next = 1'b0;
    case (state)
      DATA:    final_next = bit_tick && (bit_cnt == LAST_BIT) && !cfg_reg.par_en && !cfg_reg.stop2;
      PARITY:  final_next = bit_tick && !cfg_reg.stop2;
      STOP:    final_next = bit_tick ? (cfg_reg.stop2 && !stop_sec) : final_stop;
      default: final_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      div_reg    <= '0;
      cfg_reg    <= '0;
      par_bit    <= 1'b0;
      stop_sec   <= 1'b0;
      run_reg    <= 1'b0;
      tx         <= UART_IDLE_LVL;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      run_reg    <= 1'b1;
      frame_done <= final_next && tick_next;
      if (pop) begin
        state           <= START;
        shift_reg       <= fifo_rd_data;
        div_reg         <= baud_div;
        cfg_reg.par_en  <= par_en;
        cfg_reg.par_odd <= par_odd;
        cfg_reg.stop2   <= stop2;
        par_bit         <= (^fifo_rd_data) ^ par_odd;
        bit_cnt         <= '0;
        stop_sec        <= 1'b0;
        tx              <= 1'b0;
        busy            <= 1'b1;
      end else if (bit_tick) begin
        case (state)
          START: begin
            state     <= DATA;
            tx        <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
          end
          DATA: begin
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              if (cfg_reg.par_en) begin
                state <= PARITY;
                tx    <= par_bit;
              end else begin
                state <= STOP;
                tx    <= UART_IDLE_LVL;
              end
            end else begin
              bit_cnt   <= bit_cnt + CNT_W'(1);
              tx        <= shift_reg[0];
              shift_reg <= shift_reg >> 1;
            end
          end
          PARITY: begin
            state <= STOP;
            tx    <= UART_IDLE_LVL;
          end
          STOP: begin
            if (final_stop) begin
              state    <= IDLE;
              stop_sec <= 1'b0;
              busy     <= 1'b0;
            end else begin
              stop_sec <= 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            tx    <= UART_IDLE_LVL;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
